// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA pattern generator.
//   BAR_LUT  - 8-entry colour-bar table, {r,g,b} on/off bits per entry
//   mode_e   - pattern select encodings
//   DEF_*    - 640x480@60 timing defaults
//   clog2    - ceiling log2 for elaboration-time width math
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_CHK  = 2'd1,
    MODE_MOVE = 2'd2,
    MODE_RAMP = 2'd3
  } mode_e;

  // Index 0 is the last element: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_LUT = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters plus registered sync, de, x, y.
//   clk, rst_n, pix_en  - clock, async active-low reset, pixel-rate enable
//   h_cnt, v_cnt        - live counters (one tick ahead of x/y)
//   line_wrap           - h_cnt is at its last value this tick
//   frame_wrap          - both counters wrap to (0,0) this tick
//   active              - counters are inside the visible region
//   hsync, vsync, de, x, y - registered outputs, aligned with each other
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int XW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int YW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [XW-1:0] h_cnt,
  output logic [YW-1:0] v_cnt,
  output logic          line_wrap,
  output logic          frame_wrap,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam logic [XW-1:0] H_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [XW-1:0] H_ACT   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [YW-1:0] V_ACT   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic hs_act, vs_act;

  assign line_wrap  = (h_cnt == H_LAST);
  assign frame_wrap = line_wrap && (v_cnt == V_LAST);
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act     = (h_cnt >= HS_BEG) && (h_cnt <= HS_LAST);
  assign vs_act     = (v_cnt >= VS_BEG) && (v_cnt <= VS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      x     <= '0;
      y     <= '0;
      de    <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else if (pix_en) begin
      h_cnt <= line_wrap ? '0 : h_cnt + 1'b1;
      if (line_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      // Outputs lag the counters by one tick so they line up with the registered RGB.
      x     <= h_cnt;
      y     <= v_cnt;
      de    <= active;
      hsync <= hs_act ? HS_POL : ~HS_POL;
      vsync <= vs_act ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator.
//   clk, rst_n   - clock, async active-low reset
//   pix_en       - pixel-rate enable; state advances only when high
//   mode         - 0 bars, 1 checker, 2 moving bar, 3 grey ramp (latched per frame)
//   hsync, vsync, de, x, y, r, g, b - registered, mutually aligned video outputs
//   frame_start  - one-clk pulse when the outputs present pixel (0,0)
// Optional: define VGA_BORDER_EN to force the outermost active ring to white.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RGB_W    = 4,
  parameter int NUM_BARS = 8,
  parameter int CHK_LOG2 = 5,
  localparam int XW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int YW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic [1:0]       mode,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic [RGB_W-1:0] r,
  output logic [RGB_W-1:0] g,
  output logic [RGB_W-1:0] b,
  output logic             frame_start
);

  localparam int            BAR_W    = H_ACTIVE / NUM_BARS;
  localparam logic [XW-1:0] BAR_W_M1 = XW'(BAR_W - 1);
  localparam logic [XW-1:0] LAST_BAR = XW'(NUM_BARS - 1);
  localparam logic [XW-1:0] H_ACT_M1 = XW'(H_ACTIVE - 1);
  localparam logic [XW:0]   BAR_W_X  = (XW+1)'(BAR_W);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          line_wrap, frame_wrap, active;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .line_wrap(line_wrap), .frame_wrap(frame_wrap), .active(active),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y)
  );

  mode_e         mode_q, mode_n;
  logic [XW-1:0] pos;      // moving-bar left column
  logic [XW-1:0] bar_cnt;  // pixel offset inside the current bar
  logic [XW-1:0] bar_idx;  // bar under h_cnt; parks on the last bar
  logic [2:0]    lut;
  logic          lit;
  logic [RGB_W-1:0] pix_r, pix_g, pix_b;

  assign mode_n = mode_e'(mode);
  assign lut    = BAR_LUT[bar_idx[2:0]];
  // Right-edge clipping falls out of the de blanking; the bar never wraps.
  assign lit    = (h_cnt >= pos) && ({1'b0, h_cnt} < ({1'b0, pos} + BAR_W_X));

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (mode_q)
      MODE_BARS: begin
        pix_r = {RGB_W{lut[2]}};
        pix_g = {RGB_W{lut[1]}};
        pix_b = {RGB_W{lut[0]}};
      end
      MODE_CHK: begin
        if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
      end
      MODE_MOVE: begin
        if (lit) begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
      end
      MODE_RAMP: begin
        pix_r = h_cnt[XW-1 -: RGB_W];
        pix_g = h_cnt[XW-1 -: RGB_W];
        pix_b = h_cnt[XW-1 -: RGB_W];
      end
      default: ;
    endcase
`ifdef VGA_BORDER_EN
    if ((h_cnt == '0) || (h_cnt == H_ACT_M1) ||
        (v_cnt == '0) || (v_cnt == YW'(V_ACTIVE - 1))) begin
      pix_r = '1;
      pix_g = '1;
      pix_b = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_BARS;
      pos         <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      frame_start <= 1'b0;
    end else begin
      // Evaluated every clk so the pulse is one clk wide even with a sparse pix_en.
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        r <= active ? pix_r : '0;
        g <= active ? pix_g : '0;
        b <= active ? pix_b : '0;

        // Bar tracker follows h_cnt without a divider; the last bar soaks up the remainder.
        if (line_wrap) begin
          bar_cnt <= '0;
          bar_idx <= '0;
        end else if ((bar_cnt == BAR_W_M1) && (bar_idx != LAST_BAR)) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_cnt <= bar_cnt + 1'b1;
        end

        if (frame_wrap) begin
          mode_q <= mode_n;
          if ((mode_n == MODE_MOVE) && (mode_q != MODE_MOVE)) pos <= '0;
          else if (mode_q == MODE_MOVE) pos <= (pos == H_ACT_M1) ? '0 : pos + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks on four instances sharing clk/rst_n/pix_en:
// default 640x480 timing, a scaled 80x55 frame (8 and 3 bars) and a tiny 11x5
// frame for the moving bar. tk counts enabled ticks since reset release; the
// outputs sampled on a negedge show pixel index tk-1.
module tb_vga_pattern_gen;

  logic clk, rst_n, pix_en;
  logic [1:0] mode_d, mode_m, mode_3, mode_s;

  logic hsync_d, vsync_d, de_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [3:0] r_d, g_d, b_d;
  logic hsync_m, vsync_m, de_m, fs_m;
  logic [6:0] x_m;
  logic [5:0] y_m;
  logic [3:0] r_m, g_m, b_m;
  logic hsync_3, vsync_3, de_3, fs_3;
  logic [6:0] x_3;
  logic [5:0] y_3;
  logic [3:0] r_3, g_3, b_3;
  logic hsync_s, vsync_s, de_s, fs_s;
  logic [3:0] x_s;
  logic [2:0] y_s;
  logic [3:0] r_s, g_s, b_s;

  logic [11:0] rgb_d, rgb_m, rgb_3, rgb_s;
  assign rgb_d = {r_d, g_d, b_d};
  assign rgb_m = {r_m, g_m, b_m};
  assign rgb_3 = {r_3, g_3, b_3};
  assign rgb_s = {r_s, g_s, b_s};

  int checks = 0;
  int fails  = 0;
  int tk;
  int pe_div = 1;
  int pe_cnt = 0;
  int nlow_d, nlow_m;
  int fr [5] = '{1, 2, 3, 8, 9};

  vga_pattern_gen dut_d (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode_d),
    .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .x(x_d), .y(y_d),
    .r(r_d), .g(g_d), .b(b_d), .frame_start(fs_d)
  );

  vga_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .NUM_BARS(8), .CHK_LOG2(5)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode_m),
    .hsync(hsync_m), .vsync(vsync_m), .de(de_m), .x(x_m), .y(y_m),
    .r(r_m), .g(g_m), .b(b_m), .frame_start(fs_m)
  );

  vga_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .NUM_BARS(3), .CHK_LOG2(5)
  ) dut_3 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode_3),
    .hsync(hsync_3), .vsync(vsync_3), .de(de_3), .x(x_3), .y(y_3),
    .r(r_3), .g(g_3), .b(b_3), .frame_start(fs_3)
  );

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .NUM_BARS(4), .CHK_LOG2(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .x(x_s), .y(y_s),
    .r(r_s), .g(g_s), .b(b_s), .frame_start(fs_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pix_en high on one clk out of every pe_div.
  initial begin
    pix_en = 1'b0;
    forever begin
      @(negedge clk);
      pe_cnt = (pe_cnt + 1) % pe_div;
      pix_en = (pe_cnt == 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tk <= 0;
    else if (pix_en) tk <= tk + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected colour with the optional white border applied.
  function automatic logic [11:0] bord(input logic [11:0] e, input int px, input int py,
                                       input int ha, input int va);
`ifdef VGA_BORDER_EN
    if (px == 0 || px == ha - 1 || py == 0 || py == va - 1) return 12'hFFF;
`endif
    return e;
  endfunction

  task automatic wait_tick(input int k);
    int guard;
    guard = 0;
    while (tk < k + 1 && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    if (tk != k + 1) chk($sformatf("wait_tick_%0d", k), tk, k + 1);
  endtask

  initial begin
    rst_n  = 1'b0;
    mode_d = 2'd0;
    mode_m = 2'd0;
    mode_3 = 2'd0;
    mode_s = 2'd2;
    nlow_d = 0;
    nlow_m = 0;
    repeat (3) @(negedge clk);

    chk("rst_de",  de_m, 0);
    chk("rst_hs",  hsync_m, 1);
    chk("rst_vs",  vsync_m, 1);
    chk("rst_xy",  {x_m, y_m}, 0);
    chk("rst_rgb", rgb_m, 0);
    chk("rst_fs",  fs_m, 0);
    rst_n = 1'b1;

    // Tiny frame: 11x5, 8 active columns, bar 2 wide, mode 2 requested from the start.
    wait_tick(0);
    chk("s_fs0", fs_s, 1);
    wait_tick(11);
    chk("s_f0_bars", rgb_s, bord(12'hFFF, 0, 1, 8, 2));
    foreach (fr[i]) begin
      for (int px = 0; px < 8; px++) begin
        int p;
        p = (fr[i] - 1) % 8;
        wait_tick(fr[i] * 55 + 11 + px);
        chk($sformatf("s_mv_f%0d_x%0d", fr[i], px), rgb_s,
            bord((px >= p && px < p + 2) ? 12'hFFF : 12'h000, px, 1, 8, 2));
      end
    end

    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("d_rst_hs",  hsync_d, 1);
    chk("d_rst_vs",  vsync_d, 1);
    chk("d_rst_rgb", rgb_d, 0);
    chk("d_rst_fs",  fs_d, 0);
    rst_n = 1'b1;

    // Line 0 sweep: default timing, scaled 8 bars, scaled 3 bars.
    for (int k = 0; k < 800; k++) begin
      wait_tick(k);
      if (!hsync_d) nlow_d++;
      if (k < 80 && !hsync_m) nlow_m++;
      case (k)
        0: begin
          chk("d_fs0", fs_d, 1);
          chk("d_xy0", {x_d, y_d}, 0);
          chk("d_x0",  rgb_d, bord(12'hFFF, 0, 0, 640, 480));
        end
        1:   chk("d_fs1", fs_d, 0);
        8:   chk("m_x8",  rgb_m, bord(12'hFF0, 8, 0, 64, 48));
        20:  chk("b3_x20", rgb_3, bord(12'hFFF, 20, 0, 64, 48));
        21:  chk("b3_x21", rgb_3, bord(12'hFF0, 21, 0, 64, 48));
        41:  chk("b3_x41", rgb_3, bord(12'hFF0, 41, 0, 64, 48));
        42:  chk("b3_x42", rgb_3, bord(12'h0FF, 42, 0, 64, 48));
        47:  chk("m_x47", rgb_m, bord(12'hF00, 47, 0, 64, 48));
        48:  chk("m_x48", rgb_m, bord(12'h00F, 48, 0, 64, 48));
        56:  chk("m_x56", rgb_m, bord(12'h000, 56, 0, 64, 48));
        63:  chk("b3_x63", rgb_3, bord(12'h0FF, 63, 0, 64, 48));
        67:  chk("m_hs67", hsync_m, 1);
        68:  chk("m_hs68", hsync_m, 0);
        75:  chk("m_hs75", hsync_m, 0);
        76:  chk("m_hs76", hsync_m, 1);
        80:  chk("d_x80",  rgb_d, bord(12'hFF0, 80, 0, 640, 480));
        480: chk("d_x480", rgb_d, bord(12'h00F, 480, 0, 640, 480));
        559: chk("d_x559", rgb_d, bord(12'h00F, 559, 0, 640, 480));
        560: chk("d_x560", rgb_d, bord(12'h000, 560, 0, 640, 480));
        639: chk("d_x639", rgb_d, bord(12'h000, 639, 0, 640, 480));
        640: begin
          chk("d_de640",  de_d, 0);
          chk("d_rgb640", rgb_d, 0);
        end
        655: chk("d_hs655", hsync_d, 1);
        656: chk("d_hs656", hsync_d, 0);
        751: chk("d_hs751", hsync_d, 0);
        752: chk("d_hs752", hsync_d, 1);
        default: ;
      endcase
    end
    chk("d_hs_width", nlow_d, 96);
    chk("m_hs_width", nlow_m, 8);
    wait_tick(1455);
    chk("d_line1_hs655", hsync_d, 1);
    wait_tick(1456);
    chk("d_line1_hs656", hsync_d, 0);

    // Mid-frame switch to checker: bars hold until the frame ends.
    mode_m = 2'd1;
    wait_tick(20 * 80 + 8);
    chk("m_bars_persist", rgb_m, bord(12'hFF0, 8, 20, 64, 48));
    wait_tick(47 * 80 + 63);
    chk("m_de_47_63", de_m, 1);
    wait_tick(47 * 80 + 64);
    chk("m_de_47_64", de_m, 0);
    wait_tick(49 * 80);
    chk("m_vs49", vsync_m, 1);
    wait_tick(50 * 80);
    chk("m_vs50", vsync_m, 0);
    wait_tick(51 * 80 + 79);
    chk("m_vs51", vsync_m, 0);
    wait_tick(52 * 80);
    chk("m_vs52", vsync_m, 1);
    wait_tick(4399);
    chk("m_fs4399", fs_m, 0);
    wait_tick(4400);
    chk("m_fs4400", fs_m, 1);
    chk("m_xy4400", {x_m, y_m}, 0);
    wait_tick(4400 + 32);
    chk("m_chk_32_0", rgb_m, bord(12'hFFF, 32, 0, 64, 48));
    wait_tick(4400 + 31 * 80 + 31);
    chk("m_chk_31_31", rgb_m, bord(12'h000, 31, 31, 64, 48));
    wait_tick(4400 + 32 * 80 + 32);
    chk("m_chk_32_32", rgb_m, bord(12'h000, 32, 32, 64, 48));

    // Grey ramp next frame: value = x[6:3].
    mode_m = 2'd3;
    wait_tick(8800 + 5 * 80 + 40);
    chk("m_ramp_40", rgb_m, bord(12'h555, 40, 5, 64, 48));
    wait_tick(8800 + 5 * 80 + 63);
    chk("m_ramp_63", rgb_m, bord(12'h777, 63, 5, 64, 48));

    // Sparse pix_en, then an asynchronous reset in the middle of the frame.
    pe_div = 4;
    wait_tick(8800 + 6 * 80 + 20);
    chk("c_pre_de",  de_m, 1);
    chk("c_pre_rgb", rgb_m, bord(12'h222, 20, 6, 64, 48));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_de",  de_m, 0);
    chk("c_rst_xy",  {x_m, y_m}, 0);
    chk("c_rst_rgb", rgb_m, 0);
    chk("c_rst_hs",  hsync_m, 1);
    chk("c_rst_vs",  vsync_m, 1);
    chk("c_rst_fs",  fs_m, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(0);
    chk("c_fs0",  fs_m, 1);
    chk("c_xy0",  {x_m, y_m}, 0);
    chk("c_rgb0", rgb_m, bord(12'hFFF, 0, 0, 64, 48));
    @(negedge clk);
    chk("c_fs_pulse", fs_m, 0);
    wait_tick(1);
    @(negedge clk);
    chk("c_hold_x", x_m, 1);
    wait_tick(4400);
    chk("c_fs_f1",   fs_m, 1);
    chk("c_ramp_00", rgb_m, bord(12'h000, 0, 0, 64, 48));
    wait_tick(4400 + 80 + 40);
    chk("c_ramp_40_1", rgb_m, bord(12'h555, 40, 1, 64, 48));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
